// File: rtl/commit_trace_buffer_if.sv
// Drain port of the commit trace buffer: first-word-fall-through head entry
// with a valid/ready handshake.
interface commit_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic              rd_wen;
  logic [4:0]        rd_waddr;
  logic [DATA_W-1:0] rd_wdata;
  logic [CNT_W-1:0]  rd_seq;

  modport master (
    output rd_valid, rd_pc, rd_inst, rd_wen, rd_waddr, rd_wdata, rd_seq,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_inst, rd_wen, rd_waddr, rd_wdata, rd_seq,
    output rd_ready
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retirement-trace recorder: detects commits as pc changes, attributes register
// writes to the retiring instruction, and queues one record per commit.
module commit_trace_buffer #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [DATA_W-1:0]        inst,
  input  logic                     rf_we,
  input  logic [4:0]               rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     arm,
  input  logic                     mode_wrap,
  commit_trace_buffer_if.master    rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         retired
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              wen;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  seq;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_pre_q, pc_pre_d;
  logic [DATA_W-1:0] inst_pre_q, inst_pre_d;
  logic              pw_en_q, pw_en_d;
  logic [4:0]        pw_addr_q, pw_addr_d;
  logic [DATA_W-1:0] pw_data_q, pw_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  rec_t mem_q [DEPTH];
  rec_t rec, head;
  logic commit, pop, push, ovw, is_full;

  always_comb begin
    commit  = (pc != pc_pre_q);
    is_full = (count_q == OCC_W'(DEPTH));
    pop     = (count_q != '0) && rd.rd_ready;

    // A write in the commit cycle itself beats any earlier pending write.
    rec.pc    = pc_pre_q;
    rec.inst  = inst_pre_q;
    rec.wen   = rf_we ? 1'b1     : pw_en_q;
    rec.waddr = rf_we ? rf_waddr : pw_addr_q;
    rec.wdata = rf_we ? rf_wdata : pw_data_q;
    rec.seq   = retired_q;

    pc_pre_d   = commit ? pc : pc_pre_q;
    // inst is stable for a given pc, so following it every cycle leaves the
    // word fetched at pc_pre here on the commit edge.
    inst_pre_d = inst;
    retired_d  = commit ? retired_q + 1'b1 : retired_q;

    pw_en_d   = pw_en_q;
    pw_addr_d = pw_addr_q;
    pw_data_d = pw_data_q;
    if (commit) begin
      pw_en_d   = 1'b0;
      pw_addr_d = '0;
      pw_data_d = '0;
    end else if (rf_we) begin
      pw_en_d   = 1'b1;
      pw_addr_d = rf_waddr;
      pw_data_d = rf_wdata;
    end

    state_d    = state_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    ovw        = 1'b0;
    case (state_q)
      S_IDLE: if (arm) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (commit) begin
          if (!is_full || pop) begin
            push = 1'b1;
          end else if (mode_wrap) begin
            push       = 1'b1;
            ovw        = 1'b1;
            overflow_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
            state_d    = S_HALT;
          end
        end
        if (!arm && state_d == S_CAPTURE) state_d = S_IDLE;
      end
      S_HALT: if (!arm) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = (pop || ovw) ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop && !ovw) count_d = count_q + 1'b1;
    else if (pop && !push)    count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_pre_q   <= RESET_PC;
      inst_pre_q <= '0;
      pw_en_q    <= 1'b0;
      pw_addr_q  <= '0;
      pw_data_q  <= '0;
      retired_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_pre_q   <= pc_pre_d;
      inst_pre_q <= inst_pre_d;
      pw_en_q    <= pw_en_d;
      pw_addr_q  <= pw_addr_d;
      pw_data_q  <= pw_data_d;
      retired_q  <= retired_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset so it can map onto RAM; count gates validity.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= rec;
  end

  always_comb begin
    head        = mem_q[rptr_q];
    rd.rd_valid = (count_q != '0);
    rd.rd_pc    = head.pc;
    rd.rd_inst  = head.inst;
    rd.rd_wen   = head.wen;
    rd.rd_waddr = head.waddr;
    rd.rd_wdata = head.wdata;
    rd.rd_seq   = head.seq;
  end

  assign count    = count_q;
  assign full     = is_full;
  assign overflow = overflow_q;
  assign retired  = retired_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: capture, stop/wrap on full,
// simultaneous push/pop, arm gating and mid-run reset.
module tb_commit_trace_buffer;
  localparam logic [31:0] RPC = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, inst, rf_wdata;
  logic        rf_we, arm, mode_wrap;
  logic [4:0]  rf_waddr;
  logic [4:0]  count;
  logic        full, overflow;
  logic [15:0] retired;
  logic [31:0] cur_pc;
  int checks = 0;
  int failures = 0;

  commit_trace_buffer_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) rd_if ();

  commit_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .CNT_W(16), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .arm(arm), .mode_wrap(mode_wrap), .rd(rd_if.master),
    .count(count), .full(full), .overflow(overflow), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_step();
    cur_pc = cur_pc + 32'd4;
    pc     = cur_pc;
    inst   = {16'h2400, cur_pc[15:0]};
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; pc = RPC; cur_pc = RPC; inst = 32'h0; arm = 1'b0; mode_wrap = 1'b0;
    rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'h0; rd_if.rd_ready = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rd_if.rd_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got full=%0b ovf=%0b exp=0,0", full, overflow); end
    checks++; if (retired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_basic();
    do_reset();
    arm = 1'b1; inst = 32'h24010005; rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'd5;
    cyc();
    rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
    pc = 32'h00400004; inst = 32'h0;
    cyc();
    checks++; if (rd_if.rd_valid !== 1'b1 || count !== 5'd1) begin failures++; $display("FAIL basic_latency got valid=%0b count=%0d exp=1,1", rd_if.rd_valid, count); end
    checks++; if (rd_if.rd_pc !== 32'h00400000 || rd_if.rd_inst !== 32'h24010005) begin failures++; $display("FAIL basic_head_pc_inst got=%h/%h exp=00400000/24010005", rd_if.rd_pc, rd_if.rd_inst); end
    checks++; if (rd_if.rd_wen !== 1'b1 || rd_if.rd_waddr !== 5'd1 || rd_if.rd_wdata !== 32'd5 || rd_if.rd_seq !== 16'd0) begin
      failures++; $display("FAIL basic_head_write got wen=%0b wa=%0d wd=%0d seq=%0d exp=1,1,5,0", rd_if.rd_wen, rd_if.rd_waddr, rd_if.rd_wdata, rd_if.rd_seq); end
    pc = 32'h00400008;
    cyc();
    rd_if.rd_ready = 1'b1;
    cyc();
    rd_if.rd_ready = 1'b0;
    checks++; if (rd_if.rd_pc !== 32'h00400004 || rd_if.rd_wen !== 1'b0 || rd_if.rd_seq !== 16'd1 || count !== 5'd1) begin
      failures++; $display("FAIL basic_second got pc=%h wen=%0b seq=%0d count=%0d exp=00400004,0,1,1", rd_if.rd_pc, rd_if.rd_wen, rd_if.rd_seq, count); end
    checks++; if (retired !== 16'd2) begin failures++; $display("FAIL basic_retired got=%0d exp=2", retired); end
  endtask

  task automatic test_stop_full();
    do_reset();
    arm = 1'b1; cyc();
    for (int i = 0; i < 20; i++) commit_step();
    checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL stop_state got count=%0d full=%0b ovf=%0b exp=16,1,1", count, full, overflow); end
    checks++; if (retired !== 16'd20) begin failures++; $display("FAIL stop_retired got=%0d exp=20", retired); end
    checks++; if (rd_if.rd_pc !== RPC) begin failures++; $display("FAIL stop_head_pc got=%h exp=%h", rd_if.rd_pc, RPC); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_if.rd_seq !== 16'(i)) begin failures++; $display("FAIL stop_drain got=%0d exp=%0d", rd_if.rd_seq, i); end
      rd_if.rd_ready = 1'b1; cyc(); rd_if.rd_ready = 1'b0;
    end
    commit_step();
    checks++; if (rd_if.rd_valid !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL stop_halt_nopush got valid=%0b count=%0d exp=0,0", rd_if.rd_valid, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    mode_wrap = 1'b1; arm = 1'b1; cyc();
    for (int i = 0; i < 20; i++) commit_step();
    checks++; if (count !== 5'd16 || overflow !== 1'b1 || retired !== 16'd20) begin failures++; $display("FAIL wrap_state got count=%0d ovf=%0b ret=%0d exp=16,1,20", count, overflow, retired); end
    checks++; if (rd_if.rd_pc !== 32'h00400010) begin failures++; $display("FAIL wrap_head_pc got=%h exp=00400010", rd_if.rd_pc); end
    for (int i = 4; i < 20; i++) begin
      checks++; if (rd_if.rd_seq !== 16'(i)) begin failures++; $display("FAIL wrap_drain got=%0d exp=%0d", rd_if.rd_seq, i); end
      rd_if.rd_ready = 1'b1; cyc(); rd_if.rd_ready = 1'b0;
    end
    checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%0b exp=0", rd_if.rd_valid); end
  endtask

  task automatic test_full_pop();
    do_reset();
    arm = 1'b1; cyc();
    for (int i = 0; i < 16; i++) commit_step();
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_pre got count=%0d ovf=%0b exp=16,0", count, overflow); end
    rd_if.rd_ready = 1'b1; commit_step(); rd_if.rd_ready = 1'b0;
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_count got count=%0d ovf=%0b exp=16,0", count, overflow); end
    checks++; if (rd_if.rd_seq !== 16'd1) begin failures++; $display("FAIL fullpop_head got=%0d exp=1", rd_if.rd_seq); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arm = 1'b1; cyc();
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) commit_step();
    rd_if.rd_ready = 1'b0;
    checks++; if (count !== 5'd1 || rd_if.rd_seq !== 16'd4) begin failures++; $display("FAIL b2b got count=%0d seq=%0d exp=1,4", count, rd_if.rd_seq); end
  endtask

  task automatic test_arm_gap();
    do_reset();
    for (int i = 0; i < 3; i++) commit_step();
    checks++; if (count !== 5'd0 || retired !== 16'd3) begin failures++; $display("FAIL gap_unarmed got count=%0d ret=%0d exp=0,3", count, retired); end
    arm = 1'b1; cyc();
    commit_step(); commit_step();
    checks++; if (count !== 5'd2 || rd_if.rd_seq !== 16'd3 || rd_if.rd_pc !== 32'h0040000c) begin
      failures++; $display("FAIL gap_first got count=%0d seq=%0d pc=%h exp=2,3,0040000c", count, rd_if.rd_seq, rd_if.rd_pc); end
  endtask

  task automatic test_arm_edge();
    do_reset();
    arm = 1'b1; commit_step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL armedge_same got count=%0d exp=0", count); end
    commit_step();
    checks++; if (count !== 5'd1 || rd_if.rd_seq !== 16'd1) begin failures++; $display("FAIL armedge_next got count=%0d seq=%0d exp=1,1", count, rd_if.rd_seq); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arm = 1'b1; cyc();
    for (int i = 0; i < 17; i++) commit_step();
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    rd_if.rd_ready = 1'b0;
    checks++; if (count !== 5'd7 || overflow !== 1'b1) begin failures++; $display("FAIL midrst_pre got count=%0d ovf=%0b exp=7,1", count, overflow); end
    reset = 1'b1; pc = RPC; cur_pc = RPC; cyc();
    reset = 1'b0;
    checks++; if (count !== 5'd0 || rd_if.rd_valid !== 1'b0 || overflow !== 1'b0 || retired !== 16'd0) begin
      failures++; $display("FAIL midrst_clear got count=%0d valid=%0b ovf=%0b ret=%0d exp=0,0,0,0", count, rd_if.rd_valid, overflow, retired); end
    cyc();
    checks++; if (retired !== 16'd0 || count !== 5'd0) begin failures++; $display("FAIL midrst_nocommit got ret=%0d count=%0d exp=0,0", retired, count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_full();
    test_wrap();
    test_full_pop();
    test_back_to_back();
    test_arm_gap();
    test_arm_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retirement-trace recorder for the multicycle 54-instruction MIPS core. It watches the core's `pc`/`inst` outputs and register-file write port, detects each instruction commit as a change of `pc`, and pushes one record per retired instruction (pc, instruction word, register write, sequence number) into a parametrised circular buffer. The buffer is drained through a valid/ready port. It sits beside `sccomp_dataflow` as an on-chip replacement for simulation-only trace dumping, and supports stop-on-full and wrap (keep-latest) modes.

## Interface
- `ADDR_W`, 32, pc width
- `DATA_W`, 32, instruction and register-data width
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `CNT_W`, 16, retired-counter and sequence-number width
- `RESET_PC`, 32'h00400000, pc value the core holds out of reset

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  ADDR_W  core program counter
- `inst`  in  DATA_W  instruction at `pc`
- `rf_we`  in  1  register-file write enable
- `rf_waddr`  in  5  register-file write address
- `rf_wdata`  in  DATA_W  register-file write data
- `arm`  in  1  level; capture is enabled while high
- `mode_wrap`  in  1  0 = stop-on-full, 1 = overwrite oldest; sampled every cycle
- `rd_ready`  in  1  consumer accepts head entry
- `rd_valid`  out  1  head entry present
- `rd_pc`  out  ADDR_W  head pc
- `rd_inst`  out  DATA_W  head instruction
- `rd_wen`  out  1  head instruction wrote a register
- `rd_waddr`  out  5  head write address
- `rd_wdata`  out  DATA_W  head write data
- `rd_seq`  out  CNT_W  head sequence number
- `count`  out  log2(DEPTH)+1  occupied entries
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky; a record was dropped or overwritten
- `retired`  out  CNT_W  total commits since reset

## Operation
- Trackers: `pc_pre` resets to RESET_PC and `inst_pre` resets to 0. Pending write: `pw_en`, `pw_addr`, `pw_data`, all reset to 0.
- Commit event: `pc != pc_pre` in a cycle.
  - On that edge, `pc_pre<=pc` and `inst_pre<=inst`.
  - The record is {`pc_pre`, `inst_pre`, write info, `retired`}.
  - `retired` increments, wrapping modulo 2^CNT_W. The first commit therefore carries seq 0.
- Write attribution: an `rf_we` cycle belongs to the instruction retiring at the next commit, including a write in the commit cycle itself.
  - The last write wins.
  - If `rf_we` is high in the commit cycle, the record uses the live `rf_waddr`/`rf_wdata`. Otherwise it uses the pending write.
  - Pending-write state clears on every commit.
  - Writes to `rf_waddr==0` are recorded as-is.
- FSM states: IDLE, CAPTURE, HALT.
  - IDLE: no pushes. `arm`=1 → CAPTURE.
  - CAPTURE: each commit pushes one record. If `arm`=0 → IDLE.
  - Commit while `full` and `mode_wrap`=0: record dropped, `overflow`<=1, → HALT.
  - Commit while `full` and `mode_wrap`=1: oldest entry discarded (read pointer advances), new record written, `count` unchanged, `overflow`<=1.
  - HALT: no pushes. Reads still allowed. `arm`=0 → IDLE.
- `retired` and `pc_pre` track in every state, so sequence gaps show which commits were missed.
- Read port:
  - `rd_valid = (count != 0)`. `rd_*` present the head entry combinationally (first-word-fall-through).
  - A pop occurs when `rd_valid && rd_ready`.
- Simultaneous pop and push:
  - `count` unchanged, no overwrite, no overflow, even when full in either mode.
  - Push into an empty buffer with `rd_ready` high: no pop that cycle, because `rd_valid` is 0.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately so full and empty are distinguishable.

## Timing
- Reset values: `rd_valid`=0, `count`=0, `full`=0, `overflow`=0, `retired`=0, `rd_*` = entry 0 (don't-care while `rd_valid`=0). FSM = IDLE, pointers 0.
- Reset asserted mid-operation clears every item listed above on that edge. Buffered records are lost.
- Latency: commit is seen in cycle k, written at edge k+1, and `rd_valid` is high in cycle k+1.
- `arm` rising in cycle k means a commit in cycle k+1 is the first one captured. A commit in cycle k itself is not captured.
- The buffer sustains one push and one pop per cycle.

## Test plan
- Reset, `arm`=1, `pc` stepping 0x00400000→0x00400004→0x00400008 with `inst` 0x24010005 then 0x00000000, and `rf_we`/waddr 1/wdata 5 during the first instruction.
  - Head entry: pc 0x00400000, inst 0x24010005, wen 1, waddr 1, wdata 5, seq 0.
  - Second entry: pc 0x00400004, wen 0, seq 1.
- DEPTH=16, `mode_wrap`=0, `rd_ready`=0, 20 commits.
  - `count`=16, `full`=1, `overflow`=1, FSM in HALT, `retired`=20.
  - Draining returns seq 0..15.
- Same stimulus with `mode_wrap`=1: draining returns seq 4..19, `overflow`=1.
- Buffer full, commit in the same cycle as `rd_ready`=1: `count` stays 16, `overflow` stays 0, head advances by one.
- `arm`=0 during 3 commits, then `arm`=1: first captured seq is 3, `count` reflects only the armed commits.
- Reset asserted with `count`=7 and HALT: next cycle `count`=0, `rd_valid`=0, `overflow`=0, `retired`=0. `pc` held at 0x00400000 produces no commit.
